pb_conditioner: RTL and testbench

- Input stage between the raw 21 pushbutton lines and the arithmetic/display logic in top.
- Per button: synchronize, debounce, and produce a registered level plus a one-cycle press pulse.
- Priority-encodes each press event into a 5-bit key code with a strobe, and keeps a wrapping press counter.
- Downstream operand logic (adder inputs, ss digits, LEDs) consumes held/press/code instead of raw pb.

---
 rtl/pb_conditioner_if.sv | 24 ++
 rtl/pb_conditioner.sv | 121 ++++++++++++
 tb/tb_pb_conditioner.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pb_conditioner_if.sv
// Pushbutton conditioner bundle: raw button levels in, debounced levels,
// press pulses, key code and press counter out.
interface pb_conditioner_if #(
    parameter int unsigned NBTN = 21
);
    logic [NBTN-1:0] pb;
    logic [NBTN-1:0] held;
    logic [NBTN-1:0] press;
    logic            strobe;
    logic [4:0]      code;
    logic [7:0]      count;

    // Stimulus side drives the raw buttons and observes the conditioned outputs.
    modport master (
        output pb,
        input  held, press, strobe, code, count
    );

    // Conditioner side.
    modport slave (
        input  pb,
        output held, press, strobe, code, count
    );
endinterface

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: per-button 2-flop synchronizer and debounce,
// registered level and one-cycle press pulse, lowest-index key encoder with
// strobe, and a wrapping 8-bit press counter.
// Optional feature macro: PB_AUTOREPEAT_EN (re-pulse press every REPEAT cycles
// while a button stays held).
module pb_conditioner #(
    parameter int unsigned NBTN     = 21,
    parameter int unsigned DEBOUNCE = 2,
    parameter int unsigned REPEAT   = 50
) (
    input logic             hz100,
    input logic             reset,
    pb_conditioner_if.slave bus
);
    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE - 1);

    logic [NBTN-1:0] s1_q, s2_q;
    logic [NBTN-1:0] held_q, held_d;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];
    logic [NBTN-1:0] press_q, next_press, rep_fire;
    logic            strobe_q;
    logic [4:0]      code_q, code_d;
    logic [7:0]      count_q;

    // Debounce: held follows s2 only after DEBOUNCE consecutive differing cycles.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != held_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    held_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

`ifdef PB_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT);
    localparam logic [RW-1:0] RepLast = RW'(REPEAT - 1);

    logic [RW-1:0] rep_q [NBTN];
    logic [RW-1:0] rep_d [NBTN];

    // Repeat timer runs only while held stays high across the edge, so it
    // restarts on every rise and never fires on the release edge.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NBTN; i++) begin
            rep_d[i] = '0;
            if (held_q[i] && held_d[i]) begin
                if (rep_q[i] == RepLast) begin
                    rep_fire[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + RW'(1);
                end
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            rep_q <= '{default: '0};
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = |REPEAT;
    assign rep_fire      = '0;
`endif

    assign next_press = (held_d & ~held_q) | rep_fire;

    // Lowest set bit wins; code holds its last value when nothing is pressed.
    always_comb begin
        code_d = code_q;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (next_press[i]) begin
                code_d = 5'(i);
            end
        end
    end

    // All conditioner state, including both synchronizer stages.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            held_q   <= '0;
            cnt_q    <= '{default: '0};
            press_q  <= '0;
            strobe_q <= 1'b0;
            code_q   <= '0;
            count_q  <= '0;
        end else begin
            s1_q     <= bus.pb;
            s2_q     <= s1_q;
            held_q   <= held_d;
            cnt_q    <= cnt_d;
            press_q  <= next_press;
            strobe_q <= |next_press;
            code_q   <= code_d;
            if (|next_press) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.held   = held_q;
    assign bus.press  = press_q;
    assign bus.strobe = strobe_q;
    assign bus.code   = code_q;
    assign bus.count  = count_q;
endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: vector table plus hand sequences, with a
// scoreboard of expected strobe events checked on every strobe cycle.
module tb_pb_conditioner;
    localparam int unsigned NBTN     = 21;
    localparam int unsigned DEBOUNCE = 2;
    localparam int unsigned REPEAT   = 4;

`ifdef PB_AUTOREPEAT_EN
    localparam int NPULSE = 5;
`else
    localparam int NPULSE = 1;
`endif

    logic hz100 = 1'b0;
    logic reset;

    always #5 hz100 = ~hz100;

    pb_conditioner_if #(.NBTN(NBTN)) bus ();

    pb_conditioner #(
        .NBTN    (NBTN),
        .DEBOUNCE(DEBOUNCE),
        .REPEAT  (REPEAT)
    ) dut (
        .hz100(hz100),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [NBTN-1:0] press;
        logic [4:0]      code;
        logic [7:0]      count;
    } exp_t;

    typedef struct {
        logic [NBTN-1:0] pb;
        int              hi;
        logic [NBTN-1:0] exp_press;
        logic [4:0]      exp_code;
        logic [NBTN-1:0] exp_held;
    } vec_t;

    exp_t            sb_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [7:0]      exp_count;
    logic [NBTN-1:0] held_or;
    int              press_seen;
    logic [7:0]      count_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge hz100);
        #1;
    endtask

    task automatic expect_press(input logic [NBTN-1:0] p, input logic [4:0] c);
        exp_count = exp_count + 8'd1;
        sb_q.push_back('{press: p, code: c, count: exp_count});
    endtask

    // Monitor: every strobe must match the oldest expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge hz100);
            held_or = held_or | bus.held;
            if (bus.strobe) begin
                press_seen++;
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: press 0x%0h code %0d, none expected",
                             bus.press, bus.code);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_press", 32'(bus.press), 32'(e.press));
                    check("sb_code", 32'(bus.code), 32'(e.code));
                    check("sb_count", 32'(bus.count), 32'(e.count));
                end
            end else begin
                check("press_without_strobe", 32'(bus.press), 32'd0);
            end
        end
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{pb: 21'h000008, hi: 1, exp_press: 21'h0,      exp_code: 5'd0,
                    exp_held: 21'h0};
        vecs[1] = '{pb: 21'h000008, hi: 2, exp_press: 21'h000008, exp_code: 5'd3,
                    exp_held: 21'h000008};
        vecs[2] = '{pb: 21'h000024, hi: 3, exp_press: 21'h000024, exp_code: 5'd2,
                    exp_held: 21'h000024};
        vecs[3] = '{pb: 21'h100000, hi: 3, exp_press: 21'h100000, exp_code: 5'd20,
                    exp_held: 21'h100000};
        vecs[4] = '{pb: 21'h1FFFFF, hi: 4, exp_press: 21'h1FFFFF, exp_code: 5'd0,
                    exp_held: 21'h1FFFFF};
        vecs[5] = '{pb: 21'h080400, hi: 2, exp_press: 21'h080400, exp_code: 5'd10,
                    exp_held: 21'h080400};

        reset      = 1'b0;
        bus.pb     = '0;
        exp_count  = '0;
        held_or    = '0;
        press_seen = 0;
        repeat (3) step();

        check("rst_held", 32'(bus.held), 32'd0);
        check("rst_press", 32'(bus.press), 32'd0);
        check("rst_strobe", 32'(bus.strobe), 32'd0);
        check("rst_code", 32'(bus.code), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);

        // pb[0] set before edge 0: held rises at edge 3.
        reset  = 1'b1;
        bus.pb = 21'h000001;
        expect_press(21'h000001, 5'd0);
        for (int e = 0; e <= 3; e++) begin
            step();
            if (e == 2) check("lat_held_e2", 32'(bus.held), 32'd0);
            if (e == 3) begin
                check("lat_held_e3", 32'(bus.held), 32'd1);
                check("lat_press_e3", 32'(bus.press), 32'd1);
            end
        end
`ifdef PB_AUTOREPEAT_EN
        bus.pb = '0;
`endif
        step();
        check("lat_press_e4", 32'(bus.press), 32'd0);
        check("lat_held_e4", 32'(bus.held), 32'd1);
`ifndef PB_AUTOREPEAT_EN
        repeat (10) step();
        bus.pb = '0;
`endif
        repeat (6) step();
        check("lat_release_held", 32'(bus.held), 32'd0);
        check("lat_single_pulse", 32'(press_seen), 32'd1);

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            held_or    = '0;
            press_seen = 0;
            if (vecs[v].exp_press != '0) expect_press(vecs[v].exp_press, vecs[v].exp_code);
            bus.pb = vecs[v].pb;
            repeat (vecs[v].hi) step();
            bus.pb = '0;
            repeat (8) step();
            check($sformatf("vec%0d_held_seen", v), 32'(held_or), 32'(vecs[v].exp_held));
            check($sformatf("vec%0d_held_end", v), 32'(bus.held), 32'd0);
            check($sformatf("vec%0d_strobes", v), 32'(press_seen),
                  32'((vecs[v].exp_press != '0) ? 1 : 0));
        end

        // 256 presses on pb[7]: counter wraps back to its start value.
        press_seen   = 0;
        count_before = bus.count;
        for (int n = 0; n < 256; n++) begin
            expect_press(21'h000080, 5'd7);
            bus.pb = 21'h000080;
            repeat (3) step();
            bus.pb = '0;
            repeat (4) step();
        end
        check("wrap_count", 32'(bus.count), 32'(count_before));
        check("wrap_strobes", 32'(press_seen), 32'd256);

        // pb[1] held through an asynchronous reset pulse.
        bus.pb = 21'h000002;
        expect_press(21'h000002, 5'd1);
        repeat (6) step();
        check("mid_held_before", 32'(bus.held), 32'h2);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_held", 32'(bus.held), 32'd0);
        check("mid_rst_press", 32'(bus.press), 32'd0);
        check("mid_rst_strobe", 32'(bus.strobe), 32'd0);
        check("mid_rst_code", 32'(bus.code), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_sb_drained", 32'(sb_q.size()), 32'd0);
        exp_count = '0;
        repeat (2) step();
        expect_press(21'h000002, 5'd1);
        reset = 1'b1;
        for (int e = 1; e <= DEBOUNCE + 2; e++) begin
            step();
            if (e == DEBOUNCE + 1) check("rel_held_early", 32'(bus.held), 32'd0);
            if (e == DEBOUNCE + 2) begin
                check("rel_held_rise", 32'(bus.held), 32'h2);
                check("rel_press", 32'(bus.press), 32'h2);
            end
        end
        bus.pb = '0;
        repeat (6) step();

        // pb[9] held long: one pulse, or a pulse every REPEAT cycles with autorepeat.
        press_seen = 0;
        for (int k = 0; k < NPULSE; k++) expect_press(21'h000200, 5'd9);
        bus.pb = 21'h000200;
        repeat (4) step();
        check("rep_held_rise", 32'(bus.held), 32'h200);
        repeat (15) step();
        bus.pb = '0;
        repeat (8) step();
        check("rep_pulses", 32'(press_seen), 32'(NPULSE));
        check("rep_held_end", 32'(bus.held), 32'd0);

        check("final_count", 32'(bus.count), 32'(exp_count));
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
